// File: rtl/output_out_ctrl.sv
// rtl/output_out_ctrl.sv - packs engine elements into FIFO words with flush/clear control
// Optional build macro: OUTPUT_OUT_CTRL_RELU_EN clamps negative elements to zero before packing.
module output_out_ctrl #(
    parameter int OUTPUT_WIDTH = 32,
    parameter int ELEM_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    CLEAR_FIFO,
    input  logic                    FLUSH,
    input  logic                    IN_VALID,
    input  logic [ELEM_WIDTH-1:0]   IN_DATA,
    output logic                    IN_READY,
    input  logic                    FIFO_RD_CMD,
    output logic [OUTPUT_WIDTH-1:0] FIFO_RD_DATA,
    output logic                    FIFO_EMPTY,
    output logic                    FIFO_FULL,
    output logic                    PACKING,
    output logic [15:0]             WORD_COUNT
);
    localparam int LANES = OUTPUT_WIDTH / ELEM_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, PACK, FLUSHING} state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic [OUTPUT_WIDTH-1:0] hold_q, hold_d;
    logic                    clear_prev_q, flush_prev_q;
    logic [OUTPUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic [15:0]             word_count_q;

    logic                    clear_pulse, flush_pulse, accept, wr_en, rd_en;
    logic [OUTPUT_WIDTH-1:0] wr_data;
    logic [ELEM_WIDTH-1:0]   elem;

    assign clear_pulse = CLEAR_FIFO & ~clear_prev_q;
    assign flush_pulse = FLUSH & ~flush_prev_q;

`ifdef OUTPUT_OUT_CTRL_RELU_EN
    assign elem = IN_DATA[ELEM_WIDTH-1] ? '0 : IN_DATA;
`else
    assign elem = IN_DATA;
`endif

    assign FIFO_EMPTY   = (count_q == '0);
    assign FIFO_FULL    = (count_q == CW'(FIFO_DEPTH));
    assign IN_READY     = !FIFO_FULL && (state_q != FLUSHING);
    assign PACKING      = (state_q != IDLE);
    assign WORD_COUNT   = word_count_q;
    assign FIFO_RD_DATA = FIFO_EMPTY ? '0 : mem_q[rd_ptr_q];
    assign accept       = IN_VALID & IN_READY;
    assign rd_en        = FIFO_RD_CMD & ~FIFO_EMPTY & ~clear_pulse;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        wr_en   = 1'b0;
        wr_data = hold_q;
        if (state_q == FLUSHING) begin
            // hold_q is zeroed after every write, so unused upper lanes are already zero
            if (!FIFO_FULL) begin
                wr_en   = 1'b1;
                state_d = IDLE;
                lane_d  = '0;
                hold_d  = '0;
            end
        end else begin
            if (accept) begin
                if (lane_q == LAST_LANE) begin
                    wr_en = 1'b1;
                    wr_data[int'(lane_q)*ELEM_WIDTH +: ELEM_WIDTH] = elem;
                    state_d = IDLE;
                    lane_d  = '0;
                    hold_d  = '0;
                end else begin
                    hold_d[int'(lane_q)*ELEM_WIDTH +: ELEM_WIDTH] = elem;
                    lane_d  = lane_q + LW'(1);
                    state_d = PACK;
                end
            end
            if (flush_pulse && state_d == PACK) begin
                state_d = FLUSHING;
            end
        end
        if (clear_pulse) begin
            state_d = IDLE;
            lane_d  = '0;
            hold_d  = '0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            hold_q       <= '0;
            clear_prev_q <= 1'b0;
            flush_prev_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            hold_q       <= hold_d;
            clear_prev_q <= CLEAR_FIFO;
            flush_prev_q <= FLUSH;
            if (clear_pulse) begin
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
                word_count_q <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
                    if (word_count_q != 16'hFFFF) begin
                        word_count_q <= word_count_q + 16'd1;
                    end
                end
                if (rd_en) begin
                    rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
                end
                case ({wr_en, rd_en})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETN && wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: tb/tb_output_out_ctrl.sv
// tb/tb_output_out_ctrl.sv - scoreboard bench for output_out_ctrl with a queue-based reference model
module tb_output_out_ctrl;
    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        CLEAR_FIFO = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_READY;
    logic        FIFO_RD_CMD = 1'b0;
    logic [31:0] FIFO_RD_DATA;
    logic        FIFO_EMPTY;
    logic        FIFO_FULL;
    logic        PACKING;
    logic [15:0] WORD_COUNT;

    output_out_ctrl dut (
        .CLK(CLK), .RESETN(RESETN), .CLEAR_FIFO(CLEAR_FIFO), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .FIFO_RD_CMD(FIFO_RD_CMD), .FIFO_RD_DATA(FIFO_RD_DATA),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FULL(FIFO_FULL), .PACKING(PACKING),
        .WORD_COUNT(WORD_COUNT)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  pend_q[$];
    int          mcount = 0;
    logic        mflushing = 1'b0;
    int          wc = 0;
    logic        clr_prev = 1'b0;
    logic        fl_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_elem(input logic [7:0] d);
`ifdef OUTPUT_OUT_CTRL_RELU_EN
        return d[7] ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] pack_pending();
        logic [31:0] w = 32'h0;
        foreach (pend_q[i]) w = w | (32'(pend_q[i]) << (8 * i));
        return w;
    endfunction

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w);
        if (wc < 65535) wc++;
    endtask

    task automatic check_flags();
        check("in_ready", 32'(IN_READY), 32'(mcount < 16 && !mflushing));
        check("fifo_full", 32'(FIFO_FULL), 32'(mcount == 16));
        check("fifo_empty", 32'(FIFO_EMPTY), 32'(mcount == 0));
        check("packing", 32'(PACKING), 32'(pend_q.size() > 0 || mflushing));
        check("word_count", 32'(WORD_COUNT), 32'(wc));
        if (mcount == 0) check("rd_data_when_empty", FIFO_RD_DATA, 32'h0);
    endtask

    // Called at posedge+1: checks post-edge state, predicts the next edge, drives inputs.
    task automatic step(input logic rst_n, input logic v, input logic [7:0] d,
                        input logic pop, input logic clr, input logic fl);
        logic clr_p, fl_p, acc, pop_eff, was_fl, pop_i;
        int   pushed;
        check_flags();
        pop_i  = pop;
        pushed = 0;
        if (!rst_n) begin
            pend_q.delete();
            exp_q.delete();
            mcount = 0; wc = 0; mflushing = 1'b0;
            pop_i = 1'b0;
            clr_prev = 1'b0; fl_prev = 1'b0;
        end else begin
            clr_p = clr && !clr_prev;
            fl_p  = fl && !fl_prev;
            clr_prev = clr; fl_prev = fl;
            if (clr_p) pop_i = 1'b0;
            acc     = v && (mcount < 16) && !mflushing;
            pop_eff = pop_i && (mcount > 0);
            if (clr_p) begin
                pend_q.delete();
                exp_q.delete();
                mcount = 0; wc = 0; mflushing = 1'b0;
            end else begin
                was_fl = mflushing;
                if (mflushing) begin
                    if (mcount < 16) begin
                        push_word(pack_pending());
                        pend_q.delete();
                        mflushing = 1'b0;
                        pushed = 1;
                    end
                end else if (acc) begin
                    pend_q.push_back(ref_elem(d));
                    if (pend_q.size() == 4) begin
                        push_word(pack_pending());
                        pend_q.delete();
                        pushed = 1;
                    end
                end
                if (!was_fl && fl_p && pend_q.size() > 0) mflushing = 1'b1;
                mcount = mcount + pushed - (pop_eff ? 1 : 0);
            end
        end
        RESETN = rst_n; IN_VALID = v; IN_DATA = d; FIFO_RD_CMD = pop_i;
        CLEAR_FIFO = clr; FLUSH = fl;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RESETN && FIFO_RD_CMD && !FIFO_EMPTY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_underflow: got %h expected no word", FIFO_RD_DATA);
            end else begin
                check("fifo_word", FIFO_RD_DATA, exp_q.pop_front());
            end
        end
    end

    logic [7:0] seq_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] seq_r [4] = '{8'hFF, 8'h7F, 8'h80, 8'h05};
    logic       clr_lvl, fl_lvl;

    initial begin
        @(posedge CLK);
        #1;
        step(0, 0, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);
        // four elements form one little-endian word
        for (int i = 0; i < 4; i++) step(1, 1, seq_a[i], 0, 0, 0);
        check("s1_word", FIFO_RD_DATA, 32'h44332211);
        step(1, 0, 8'h00, 1, 0, 0);
        // partial flush, FLUSH held high must not flush twice
        step(1, 1, 8'hAA, 0, 0, 0);
        step(1, 1, 8'hBB, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0, 0, 1);
        check("s2_word", FIFO_RD_DATA, 32'h0000BBAA);
        check("s2_count", 32'(WORD_COUNT), 32'd2);
        step(1, 1, 8'hCC, 0, 0, 1);
        step(1, 0, 8'h00, 1, 0, 1);
        step(1, 1, 8'hDD, 0, 0, 0);
        step(1, 1, 8'hEE, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 1);
        step(1, 0, 8'h00, 1, 0, 0);
        step(1, 0, 8'h00, 1, 0, 0);
        // flush in the same cycle as the completing element
        step(1, 1, 8'h01, 0, 0, 0);
        step(1, 1, 8'h02, 0, 0, 0);
        step(1, 1, 8'h03, 0, 0, 0);
        step(1, 1, 8'h04, 0, 0, 1);
        step(1, 0, 8'h00, 0, 0, 1);
        check("s4_word", FIFO_RD_DATA, 32'h04030201);
        step(1, 0, 8'h00, 1, 0, 0);
        // fill to full, stall, one pop, 17th word
        for (int i = 0; i < 64; i++) step(1, 1, 8'($urandom), 0, 0, 0);
        check("s3_ready_full", 32'(IN_READY), 32'd0);
        step(1, 1, 8'h5A, 0, 0, 0);
        step(1, 1, 8'h5A, 1, 0, 0);
        check("s3_ready_after_pop", 32'(IN_READY), 32'd1);
        for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h60 + i), 0, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 8'h00, 1, 0, 0);
        // clear with queued words and held lanes
        for (int i = 0; i < 14; i++) step(1, 1, 8'($urandom), 0, 0, 0);
        step(1, 1, 8'h99, 0, 1, 0);
        check("s5_empty", 32'(FIFO_EMPTY), 32'd1);
        check("s5_count", 32'(WORD_COUNT), 32'd0);
        check("s5_packing", 32'(PACKING), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 1, seq_a[i], 0, 0, 0);
        check("s5_fresh_word", FIFO_RD_DATA, 32'h44332211);
        step(1, 0, 8'h00, 1, 0, 0);
        // negative-element handling
        for (int i = 0; i < 4; i++) step(1, 1, seq_r[i], 0, 0, 0);
`ifdef OUTPUT_OUT_CTRL_RELU_EN
        check("relu_word", FIFO_RD_DATA, 32'h05007F00);
`else
        check("relu_word", FIFO_RD_DATA, 32'h05807FFF);
`endif
        step(1, 0, 8'h00, 1, 0, 0);
        // reset mid-word, with levels high at release
        step(1, 1, 8'h31, 0, 0, 0);
        step(1, 1, 8'h32, 0, 0, 0);
        step(0, 1, 8'h33, 0, 1, 1);
        step(1, 1, 8'h34, 0, 1, 1);
        step(1, 1, 8'h35, 0, 0, 0);
        clr_lvl = 1'b0;
        fl_lvl  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) clr_lvl = ~clr_lvl;
            if ($urandom_range(0, 6) == 0) fl_lvl = ~fl_lvl;
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 2) == 0), clr_lvl, fl_lvl);
        end
        for (int i = 0; i < 20; i++) step(1, 0, 8'h00, 1, 0, 0);
        check_flags();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/output_out_ctrl.md
OUTPUT_OUT_CTRL -- requirements
Module: output_out_ctrl

Interface
REQ-001 SHALL provide parameters: OUTPUT_WIDTH, default 32, FIFO word width; ELEM_WIDTH, default 8, result element width; FIFO_DEPTH, default 16, FIFO entries.
REQ-002 SHALL provide ports:
- CLK  in  1  single clock, all logic on rising edge.
- RESETN  in  1  synchronous active-low reset.
- CLEAR_FIFO  in  1  level input from mem_ctrl register; internally edge-detected to a 1-cycle pulse.
- FLUSH  in  1  level input from mem_ctrl register; internally edge-detected to a 1-cycle pulse.
- IN_VALID  in  1  engine result valid.
- IN_DATA  in  ELEM_WIDTH  signed engine result.
- IN_READY  out  1  element accepted when IN_VALID & IN_READY.
- FIFO_RD_CMD  in  1  external pop.
- FIFO_RD_DATA  out  OUTPUT_WIDTH  head word, first-word-fall-through.
- FIFO_EMPTY  out  1  FIFO holds 0 words.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH words.
- PACKING  out  1  partial word held or flush pending.
- WORD_COUNT  out  16  words pushed since reset/clear, saturating at 16'hFFFF.

Function
REQ-003 SHALL pack OUTPUT_WIDTH/ELEM_WIDTH (4) accepted elements per word, little-endian: first element in bits [7:0], fourth in [31:24].
REQ-004 SHALL implement FSM: IDLE (lane 0, nothing held), PACK (lane 1..3), FLUSHING (partial word waiting on FIFO space).
REQ-005 IN_READY SHALL be 1 iff FIFO_FULL==0 and state!=FLUSHING.
REQ-006 On acceptance with lane<3: SHALL store element in lane, lane+1, state PACK.
REQ-007 On acceptance with lane==3: SHALL assert internal FIFO write of {IN_DATA, held lanes} in the same cycle, lane->0, state IDLE; word readable at FIFO_RD_DATA the following cycle.
REQ-008 On FLUSH pulse in IDLE (after same-cycle acceptance is applied): SHALL take no action, write nothing.
REQ-009 On FLUSH pulse with lane>0 after same-cycle acceptance: SHALL enter FLUSHING; an acceptance completing a word in that cycle SHALL write that word and flush nothing.
REQ-010 In FLUSHING: SHALL write held lanes with unused upper lanes zero-filled on the first cycle FIFO_FULL==0, then return to IDLE with lane 0.
REQ-011 FIFO_RD_CMD while FIFO_EMPTY SHALL be ignored; internal write while FIFO_FULL SHALL not occur by construction.
REQ-012 Simultaneous pop and push SHALL both take effect, count unchanged.
REQ-013 CLEAR_FIFO pulse SHALL empty FIFO, discard held lanes, lane->0, state IDLE, WORD_COUNT->0; it overrides same-cycle acceptance, flush and pop (accepted element is dropped).
REQ-014 WORD_COUNT SHALL increment by 1 on every FIFO write, including flush writes.
REQ-015 PACKING SHALL equal (state!=IDLE).

Reset
REQ-016 RESETN==0 at a rising edge SHALL clear FSM to IDLE, lane 0, held data 0, FIFO empty, WORD_COUNT 0, edge-detector history 0.
REQ-017 During/after reset: IN_READY=1 (after first un-reset edge), FIFO_EMPTY=1, FIFO_FULL=0, PACKING=0, FIFO_RD_DATA=0.
REQ-018 Reset mid-word or mid-flush SHALL discard the partial word with no FIFO write.
REQ-019 A level high on CLEAR_FIFO or FLUSH at reset release SHALL produce one pulse on the first edge after release.

Configuration
REQ-020 Macro OUTPUT_OUT_CTRL_RELU_EN: when defined, each accepted IN_DATA with MSB=1 SHALL be packed as 0, others unchanged; when undefined, IN_DATA SHALL be packed unmodified. FSM, timing and ports SHALL be identical in both builds.

Verification
REQ-021 Scenarios:
- Push 8'h11,22,33,44 -> one FIFO word 32'h44332211, WORD_COUNT=1, PACKING=0.
- Push 8'hAA,8'hBB then FLUSH 0->1 -> word 32'h0000BBAA, WORD_COUNT=1; FLUSH held high gives no second word.
- Fill FIFO with 16 words -> FIFO_FULL=1, IN_READY=0; one pop -> IN_READY=1 next cycle, 17th word written in order.
- Push 8'h01,02,03, FLUSH pulse in cycle of 4th element 8'h04 -> single word 32'h04030201, no zero word.
- 3 words queued plus 2 held lanes, CLEAR_FIFO 0->1 -> FIFO_EMPTY=1, WORD_COUNT=0, PACKING=0; next 4 elements form a fresh word.
- RELU build: push 8'hFF,8'h7F,8'h80,8'h05 -> word 32'h05007F00; non-RELU build -> 32'h05807FFF.
